// File: rtl/ame_sobel_line_feeder.sv
// rtl/ame_sobel_line_feeder.sv - loads a 6x6 pixel block, feeds it line by line to the
// Sobel filter engine and holds the 4x4 gradient result for the downstream consumer.
module ame_sobel_line_feeder #(
  parameter int LINE_DATA_BITS = 7,
  parameter int COMP_DATA_BITS = 8,
  parameter int DONE_TIMEOUT   = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        blk_valid_i,
  output logic                        blk_ready_o,
  input  logic                        blk_dir_i,
  input  logic [6*LINE_DATA_BITS-1:0] blk_row_i,
  output logic                        comp_init_o,
  output logic [6*LINE_DATA_BITS-1:0] line_data_o,
  input  logic                        comp_done_i,
  input  logic [16*COMP_DATA_BITS-1:0] comp_data_i,
  output logic                        res_valid_o,
  input  logic                        res_ready_i,
  output logic                        res_dir_o,
  output logic [16*COMP_DATA_BITS-1:0] res_data_o,
  output logic                        err_o
);

  localparam int WCW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(DONE_TIMEOUT - 1);

  typedef enum logic [2:0] {S_LOAD, S_INIT, S_FEED, S_WAIT, S_OUT} state_t;

  state_t                    state;
  logic [2:0]                row_cnt;
  logic [2:0]                line_cnt;
  logic [WCW-1:0]            wait_cnt;
  logic                      dir_q;
  logic [LINE_DATA_BITS-1:0] pix [6][6];

  logic [2:0]                sel;
  logic [6*LINE_DATA_BITS-1:0] next_line;

  // Line that becomes visible on the next cycle: line 0 out of INIT, line k+1 during FEED.
  always_comb begin
    sel       = (state == S_INIT) ? 3'd0 : line_cnt + 3'd1;
    next_line = '0;
    if (sel <= 3'd5) begin
      for (int i = 0; i < 6; i++) begin
        next_line[i*LINE_DATA_BITS +: LINE_DATA_BITS] = dir_q ? pix[sel][i] : pix[i][sel];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_LOAD;
      row_cnt     <= '0;
      line_cnt    <= '0;
      wait_cnt    <= '0;
      dir_q       <= 1'b0;
      blk_ready_o <= 1'b1;
      comp_init_o <= 1'b0;
      line_data_o <= '0;
      res_valid_o <= 1'b0;
      res_dir_o   <= 1'b0;
      res_data_o  <= '0;
      err_o       <= 1'b0;
      for (int r = 0; r < 6; r++) begin
        for (int c = 0; c < 6; c++) begin
          pix[r][c] <= '0;
        end
      end
    end else begin
      comp_init_o <= 1'b0;
      if (comp_done_i && state != S_WAIT) begin
        err_o <= 1'b1;
      end
      case (state)
        S_LOAD: begin
          if (blk_valid_i) begin
            for (int c = 0; c < 6; c++) begin
              pix[row_cnt][c] <= blk_row_i[c*LINE_DATA_BITS +: LINE_DATA_BITS];
            end
            if (row_cnt == 3'd0) begin
              dir_q <= blk_dir_i;
            end
            if (row_cnt == 3'd5) begin
              row_cnt     <= '0;
              blk_ready_o <= 1'b0;
              comp_init_o <= 1'b1;
              state       <= S_INIT;
            end else begin
              row_cnt <= row_cnt + 3'd1;
            end
          end
        end
        S_INIT: begin
          line_data_o <= next_line;
          line_cnt    <= '0;
          state       <= S_FEED;
        end
        S_FEED: begin
          if (line_cnt == 3'd5) begin
            line_data_o <= '0;
            wait_cnt    <= '0;
            state       <= S_WAIT;
          end else begin
            line_data_o <= next_line;
            line_cnt    <= line_cnt + 3'd1;
          end
        end
        S_WAIT: begin
          // A done arriving on the last allowed cycle still counts.
          if (comp_done_i) begin
            res_data_o  <= comp_data_i;
            res_dir_o   <= dir_q;
            res_valid_o <= 1'b1;
            state       <= S_OUT;
          end else if (wait_cnt == WAIT_LAST) begin
            err_o       <= 1'b1;
            blk_ready_o <= 1'b1;
            state       <= S_LOAD;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_OUT: begin
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            blk_ready_o <= 1'b1;
            state       <= S_LOAD;
          end
        end
        default: begin
          blk_ready_o <= 1'b1;
          state       <= S_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ame_sobel_line_feeder.sv
// tb/tb_ame_sobel_line_feeder.sv - directed vector bench for ame_sobel_line_feeder with a
// stub filter that computes a horizontal Sobel gradient from the lines it receives.
module tb_ame_sobel_line_feeder;
  localparam int W  = 7;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            blk_valid = 1'b0;
  logic            blk_ready;
  logic            blk_dir = 1'b0;
  logic [6*W-1:0]  blk_row = '0;
  logic            comp_init;
  logic [6*W-1:0]  line_data;
  logic            comp_done = 1'b0;
  logic [16*CW-1:0] comp_data = '0;
  logic            res_valid;
  logic            res_ready = 1'b1;
  logic            res_dir;
  logic [16*CW-1:0] res_data;
  logic            err;

  ame_sobel_line_feeder #(.LINE_DATA_BITS(W), .COMP_DATA_BITS(CW), .DONE_TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .blk_valid_i(blk_valid), .blk_ready_o(blk_ready), .blk_dir_i(blk_dir), .blk_row_i(blk_row),
    .comp_init_o(comp_init), .line_data_o(line_data),
    .comp_done_i(comp_done), .comp_data_i(comp_data),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_dir_o(res_dir), .res_data_o(res_data),
    .err_o(err)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  logic exp_err = 1'b0;

  typedef struct {
    int         pat;      // 0: pix=c, 1: pix=127, 2: pix=6r+c
    logic       dir;
    logic       toggle;   // idle cycle between row beats
    int         delay;    // cycles res_ready held low after res_valid
    int         mode;     // 0: normal, 1: reset at feed k=3, 2: filter never done
    logic [7:0] exp_val;  // every result element
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pv(input int pat, input int r, input int c);
    case (pat)
      0:       return W'(c);
      1:       return W'(127);
      default: return W'(6*r + c);
    endcase
  endfunction

  task automatic run_block(input vec_t v);
    logic [W-1:0]     cap [6][6];
    logic [6*W-1:0]   el;
    logic [16*CW-1:0] model;
    int               s;
    res_ready = (v.delay == 0);
    for (int r = 0; r < 6; r++) begin
      if (v.toggle && r > 0) begin
        blk_valid = 1'b0;
        @(negedge clk);
        chk("gap_ready", blk_ready, 1);
        chk("gap_init", comp_init, 0);
        tick();
      end
      for (int c = 0; c < 6; c++) el[c*W +: W] = pv(v.pat, r, c);
      blk_valid = 1'b1;
      blk_row   = el;
      blk_dir   = (r == 0) ? v.dir : ~v.dir;
      @(negedge clk);
      chk("beat_ready", blk_ready, 1);
      chk("beat_init", comp_init, 0);
      tick();
    end
    blk_valid = 1'b0;
    @(negedge clk);
    chk("init_pulse", comp_init, 1);
    chk("init_ready", blk_ready, 0);
    tick();
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 6; i++) el[i*W +: W] = v.dir ? pv(v.pat, k, i) : pv(v.pat, i, k);
      if (v.mode == 1 && k == 3) rst = 1'b1;
      @(negedge clk);
      chk($sformatf("line%0d", k), line_data, el);
      chk("feed_init", comp_init, 0);
      chk("feed_ready", blk_ready, 0);
      for (int i = 0; i < 6; i++) cap[k][i] = line_data[i*W +: W];
      tick();
      if (v.mode == 1 && k == 3) begin
        rst = 1'b0;
        exp_err = 1'b0;
        @(negedge clk);
        chk("rst_init", comp_init, 0);
        chk("rst_line", line_data, 0);
        chk("rst_ready", blk_ready, 1);
        chk("rst_valid", res_valid, 0);
        tick();
        return;
      end
    end
    model = '0;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        s = 0;
        for (int d = 0; d < 3; d++) begin
          s += ((d == 1) ? 2 : 1) * (int'(cap[a+2][b+d]) - int'(cap[a][b+d]));
        end
        model[(a*4+b)*CW +: CW] = CW'(s);
      end
    end
    comp_done = (v.mode == 0);
    comp_data = model;
    @(negedge clk);
    chk("wait_line", line_data, 0);
    chk("wait_valid", res_valid, 0);
    tick();
    comp_done = 1'b0;
    comp_data = ~model;
    if (v.mode == 2) begin
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        chk("to_err_early", err, exp_err);
        chk("to_valid", res_valid, 0);
        tick();
      end
      exp_err = 1'b1;
      @(negedge clk);
      chk("to_err", err, 1);
      chk("to_ready", blk_ready, 1);
      chk("to_valid_after", res_valid, 0);
      tick();
      return;
    end
    @(negedge clk);
    chk("res_valid", res_valid, 1);
    chk("res_data", res_data, {16{v.exp_val}});
    chk("res_dir", res_dir, v.dir);
    chk("out_ready", blk_ready, 0);
    chk("out_err", err, exp_err);
    for (int j = 0; j < v.delay; j++) begin
      tick();
      if (j == v.delay - 1) res_ready = 1'b1;
      blk_valid = 1'b1;
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, {16{v.exp_val}});
      chk("hold_ready", blk_ready, 0);
    end
    tick();
    blk_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    chk("post_valid", res_valid, 0);
    chk("post_ready", blk_ready, 1);
    tick();
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{pat: 0, dir: 1'b0, toggle: 1'b0, delay: 0, mode: 0, exp_val: 8'd8};
    vecs[1] = '{pat: 0, dir: 1'b1, toggle: 1'b0, delay: 0, mode: 0, exp_val: 8'd0};
    vecs[2] = '{pat: 1, dir: 1'b0, toggle: 1'b1, delay: 0, mode: 0, exp_val: 8'd0};
    vecs[3] = '{pat: 2, dir: 1'b1, toggle: 1'b0, delay: 5, mode: 0, exp_val: 8'd48};
    vecs[4] = '{pat: 2, dir: 1'b0, toggle: 1'b0, delay: 0, mode: 1, exp_val: 8'd8};
    vecs[5] = '{pat: 0, dir: 1'b0, toggle: 1'b0, delay: 0, mode: 0, exp_val: 8'd8};
    vecs[6] = '{pat: 1, dir: 1'b0, toggle: 1'b0, delay: 0, mode: 2, exp_val: 8'd0};
    vecs[7] = '{pat: 0, dir: 1'b1, toggle: 1'b0, delay: 0, mode: 0, exp_val: 8'd0};

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_blk_ready", blk_ready, 1);
    chk("rst_comp_init", comp_init, 0);
    chk("rst_line_data", line_data, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_dir", res_dir, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_err", err, 0);
    tick();

    for (int n = 0; n < 7; n++) run_block(vecs[n]);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    chk("rst2_err", err, 0);
    tick();
    comp_done = 1'b1;
    @(negedge clk);
    tick();
    comp_done = 1'b0;
    exp_err = 1'b1;
    @(negedge clk);
    chk("early_done_err", err, 1);
    chk("early_done_ready", blk_ready, 1);
    chk("early_done_init", comp_init, 0);
    tick();
    run_block(vecs[7]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
endmodule
